multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle main control FSM for the simple CPU datapath; drives the ALU's 3-bit ALUctr plus all datapath mux selects and write enables.
- Sequences each instruction through fetch, decode and execute states.
- Consumes the ALU Zero flag to resolve beq.
- Sits between the instruction register (op/funct fields) and the datapath; counts retired instructions and flags illegal opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
op  input  6  IR[31:26]
funct  input  6  IR[5:0], used only when op=000000
zero  input  1  ALU Zero flag, same cycle
ALUctr  output  3  ALU op: 010 add, 110 sub, 001 or
alu_src_a  output  1  0=PC, 1=register A
alu_src_b  output  2  00=reg B, 01=const 4, 10=ext imm, 11=sign-ext imm<<2
ext_op  output  1  1=sign extend, 0=zero extend imm16
pc_wr  output  1  PC write enable
pc_src  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
ir_wr  output  1  IR write enable
mem_wr  output  1  data memory write enable
reg_wr  output  1  register file write enable
reg_dst  output  1  1=rd, 0=rt
mem_to_reg  output  1  1=memory data, 0=ALUOut
state  output  4  current state encoding (debug)
illegal  output  1  one-cycle pulse: unsupported op/funct decoded
instr_cnt  output  CNT_W  retired legal instructions

Behaviour:
- Supported instructions and opcodes:
  - addu: op=000000, funct=100001
  - subu: op=000000, funct=100011
  - ori: op=001101
  - lw: op=100011
  - sw: op=101011
  - beq: op=000100
  - j: op=000010
- State encodings: FETCH=0, DECODE=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, ORI_EX=10, ORI_WB=11.
- State transitions:
  - FETCH -> DECODE.
  - DECODE -> MEM_ADR (lw/sw), R_EX (addu/subu), BRANCH, JUMP, ORI_EX; anything else -> FETCH with illegal=1 for that cycle.
  - MEM_ADR -> MEM_RD (lw) or MEM_WR (sw); MEM_RD -> MEM_WB.
  - R_EX -> R_WB; ORI_EX -> ORI_WB.
  - MEM_WB, MEM_WR, R_WB, ORI_WB, BRANCH, JUMP -> FETCH.
- Cycle counts: lw 5, sw 4, addu/subu/ori 4, beq 3, j 3, illegal 2.
- Outputs are Moore, decoded from the state register. The exceptions are pc_wr in BRANCH (= zero, combinational), R_EX ALUctr (from funct) and MEM_ADR's next-state choice (from op).
- Outputs not listed for a state are 0.
  - FETCH: ir_wr=1, pc_wr=1, pc_src=00, alu_src_a=0, alu_src_b=01, ALUctr=010.
  - DECODE: alu_src_a=0, alu_src_b=11, ext_op=1, ALUctr=010 (branch target into ALUOut).
  - MEM_ADR: alu_src_a=1, alu_src_b=10, ext_op=1, ALUctr=010.
  - MEM_RD: memory read, no enables asserted.
  - MEM_WB: reg_wr=1, reg_dst=0, mem_to_reg=1.
  - MEM_WR: mem_wr=1.
  - R_EX: alu_src_a=1, alu_src_b=00, ALUctr=010 for addu, 110 for subu.
  - R_WB: reg_wr=1, reg_dst=1, mem_to_reg=0.
  - ORI_EX: alu_src_a=1, alu_src_b=10, ext_op=0, ALUctr=001.
  - ORI_WB: reg_wr=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, ALUctr=110, pc_src=01, pc_wr=zero.
  - JUMP: pc_src=10, pc_wr=1.
- ALUctr in states not listed above is 010.
- Reset:
  - While rst=1: pc_wr, ir_wr, mem_wr, reg_wr and illegal are forced 0 regardless of state.
  - On the clock edge with rst=1: state<=FETCH, instr_cnt<=0.
  - Reset mid-instruction abandons it and does not count it.
  - First fetch occurs in the first cycle after rst deasserts.
- instr_cnt:
  - Increments by 1 on the edge leaving any terminal state (MEM_WB, MEM_WR, R_WB, ORI_WB, BRANCH, JUMP).
  - Taken and not-taken beq both count; illegal does not.
  - Wraps modulo 2^CNT_W.
- illegal: high only in the DECODE cycle that decodes an unsupported instruction; an unsupported funct with op=000000 is illegal.
- zero is sampled only in BRANCH; zero toggling in other states has no effect.

Test Plan:
- Reset then lw (op=100011) -> states 0,1,2,3,4,0; reg_wr=1 with mem_to_reg=1 only in state 4; instr_cnt=1.
- addu then subu -> ALUctr=010 in first R_EX, 110 in second; reg_dst=1 in R_WB; instr_cnt=2.
- beq with zero=1, then beq with zero=0 -> pc_wr=1, pc_src=01 in first BRANCH; pc_wr=0 in second; each 3 cycles; instr_cnt +2.
- ori -> ALUctr=001, ext_op=0, alu_src_b=10 in ORI_EX; sw -> mem_wr=1 one cycle, reg_wr never asserted.
- op=111111, and op=000000 with funct=000000 -> illegal=1 in DECODE, return to FETCH, instr_cnt unchanged.
- rst asserted during MEM_RD -> next state FETCH, instr_cnt=0, all write enables 0 while rst=1; CNT_W=4 with 16 ori -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM for the simple CPU datapath.
// Each instruction runs through fetch, decode and execute states. The FSM
// drives the ALU control, datapath mux selects and write enables, counts
// retired instructions, and pulses `illegal` when it decodes an unsupported
// instruction.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [2:0]       ALUctr,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_op,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluOr  = 3'b001;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StREx    = 4'd6,
        StRWb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StOriEx  = 4'd10,
        StOriWb  = 4'd11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // State register; reset returns to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter; bumps on the edge leaving a terminal state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter next-state: wraps naturally modulo 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and Moore outputs, plus the few input-dependent exceptions.
    always_comb begin
        state_d    = StFetch;
        ALUctr     = AluAdd;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'b00;
        ir_wr      = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        unique case (state_q)
            StFetch: begin
                ir_wr     = 1'b1;
                pc_wr     = 1'b1;
                alu_src_b = 2'b01;
                state_d   = StDecode;
            end
            StDecode: begin
                // Precompute branch target into ALUOut while decoding.
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                unique case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpOri:      state_d = StOriEx;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpRType: begin
                        if (funct == FnAddu || funct == FnSubu) begin
                            state_d = StREx;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                state_d = StMemWb;
            end
            StMemWb: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StMemWr: begin
                mem_wr = 1'b1;
                retire = 1'b1;
            end
            StREx: begin
                alu_src_a = 1'b1;
                ALUctr    = (funct == FnSubu) ? AluSub : AluAdd;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            StOriEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ALUctr    = AluOr;
                state_d   = StOriWb;
            end
            StOriWb: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                ALUctr    = AluSub;
                pc_src    = 2'b01;
                pc_wr     = zero;
                retire    = 1'b1;
            end
            StJump: begin
                pc_src = 2'b10;
                pc_wr  = 1'b1;
                retire = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset masks every architectural side effect, whatever the state.
        if (rst) begin
            pc_wr   = 1'b0;
            ir_wr   = 1'b0;
            mem_wr  = 1'b0;
            reg_wr  = 1'b0;
            illegal = 1'b0;
            retire  = 1'b0;
        end
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level model predicts every
// per-cycle output; two DUTs (32-bit and 4-bit counter) share the stimulus.
module tb_multicycle_ctrl;

    localparam int CLw = 0, CSw = 1, CAddu = 2, CSubu = 3, COri = 4, CBeq = 5, CJ = 6, CIll = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0;

    logic [2:0]  alu_ctr, d4_alu_ctr;
    logic        src_a, d4_src_a;
    logic [1:0]  src_b, d4_src_b;
    logic        ext, d4_ext;
    logic        pc_wr, d4_pc_wr;
    logic [1:0]  pc_src, d4_pc_src;
    logic        ir_wr, d4_ir_wr;
    logic        mem_wr, d4_mem_wr;
    logic        reg_wr, d4_reg_wr;
    logic        reg_dst, d4_reg_dst;
    logic        m2r, d4_m2r;
    logic [3:0]  st, d4_st;
    logic        ill, d4_ill;
    logic [31:0] cnt;
    logic [3:0]  d4_cnt;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .ALUctr(alu_ctr), .alu_src_a(src_a), .alu_src_b(src_b), .ext_op(ext),
        .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .reg_dst(reg_dst), .mem_to_reg(m2r), .state(st), .illegal(ill), .instr_cnt(cnt)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .ALUctr(d4_alu_ctr), .alu_src_a(d4_src_a), .alu_src_b(d4_src_b), .ext_op(d4_ext),
        .pc_wr(d4_pc_wr), .pc_src(d4_pc_src), .ir_wr(d4_ir_wr), .mem_wr(d4_mem_wr),
        .reg_wr(d4_reg_wr), .reg_dst(d4_reg_dst), .mem_to_reg(d4_m2r), .state(d4_st),
        .illegal(d4_ill), .instr_cnt(d4_cnt)
    );

    always #5 clk = ~clk;

    // Expected values for the current cycle, written by the stimulus only.
    logic        exp_valid = 1'b0, exp_rst = 1'b0;
    logic [3:0]  e_state;
    logic [2:0]  e_alu;
    logic        e_a, e_ext, e_pcwr, e_irwr, e_memwr, e_regwr, e_regdst, e_m2r, e_ill;
    logic [1:0]  e_b, e_pcsrc;
    logic [31:0] e_cnt;
    logic [31:0] model_cnt = 0;
    logic        lit_en = 1'b0, lit4_en = 1'b0;
    logic [31:0] lit_val = 0, lit4_val = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (exp_valid && exp_rst) begin
            chk("rst_pc_wr", 32'(pc_wr), 0);
            chk("rst_ir_wr", 32'(ir_wr), 0);
            chk("rst_mem_wr", 32'(mem_wr), 0);
            chk("rst_reg_wr", 32'(reg_wr), 0);
            chk("rst_illegal", 32'(ill), 0);
        end else if (exp_valid) begin
            chk("state", 32'(st), 32'(e_state));
            chk("ALUctr", 32'(alu_ctr), 32'(e_alu));
            chk("alu_src_a", 32'(src_a), 32'(e_a));
            chk("alu_src_b", 32'(src_b), 32'(e_b));
            chk("ext_op", 32'(ext), 32'(e_ext));
            chk("pc_wr", 32'(pc_wr), 32'(e_pcwr));
            chk("pc_src", 32'(pc_src), 32'(e_pcsrc));
            chk("ir_wr", 32'(ir_wr), 32'(e_irwr));
            chk("mem_wr", 32'(mem_wr), 32'(e_memwr));
            chk("reg_wr", 32'(reg_wr), 32'(e_regwr));
            chk("reg_dst", 32'(reg_dst), 32'(e_regdst));
            chk("mem_to_reg", 32'(m2r), 32'(e_m2r));
            chk("illegal", 32'(ill), 32'(e_ill));
            chk("instr_cnt", cnt, e_cnt);
            chk("instr_cnt_w4", 32'(d4_cnt), 32'(e_cnt[3:0]));
            chk("state_w4", 32'(d4_st), 32'(e_state));
        end
        if (lit_en)  chk("pin_instr_cnt", cnt, lit_val);
        if (lit4_en) chk("pin_instr_cnt_w4", 32'(d4_cnt), lit4_val);
    end

    function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return CLw;
            6'b101011: return CSw;
            6'b001101: return COri;
            6'b000100: return CBeq;
            6'b000010: return CJ;
            6'b000000: return (f == 6'b100001) ? CAddu : (f == 6'b100011) ? CSubu : CIll;
            default:   return CIll;
        endcase
    endfunction

    function automatic int len_of(input int c);
        case (c)
            CLw:        return 5;
            CSw, CAddu, CSubu, COri: return 4;
            CBeq, CJ:   return 3;
            default:    return 2;
        endcase
    endfunction

    // What the datapath must see on cycle s of an instruction of class c.
    task automatic set_exp(input int c, input int s, input logic z);
        e_state = 0; e_alu = 3'b010; e_a = 0; e_b = 0; e_ext = 0; e_pcwr = 0; e_pcsrc = 0;
        e_irwr = 0; e_memwr = 0; e_regwr = 0; e_regdst = 0; e_m2r = 0; e_ill = 0;
        if (s == 0) begin
            e_irwr = 1; e_pcwr = 1; e_b = 2'b01;
        end else if (s == 1) begin
            e_state = 1; e_b = 2'b11; e_ext = 1; e_ill = (c == CIll);
        end else begin
            case (c)
                CLw, CSw: begin
                    if (s == 2) begin
                        e_state = 2; e_a = 1; e_b = 2'b10; e_ext = 1;
                    end else if (c == CSw) begin
                        e_state = 5; e_memwr = 1;
                    end else if (s == 3) begin
                        e_state = 3;
                    end else begin
                        e_state = 4; e_regwr = 1; e_m2r = 1;
                    end
                end
                CAddu, CSubu: begin
                    if (s == 2) begin
                        e_state = 6; e_a = 1; e_alu = (c == CSubu) ? 3'b110 : 3'b010;
                    end else begin
                        e_state = 7; e_regwr = 1; e_regdst = 1;
                    end
                end
                COri: begin
                    if (s == 2) begin
                        e_state = 10; e_a = 1; e_b = 2'b10; e_alu = 3'b001;
                    end else begin
                        e_state = 11; e_regwr = 1;
                    end
                end
                CBeq: begin
                    e_state = 8; e_a = 1; e_alu = 3'b110; e_pcsrc = 2'b01; e_pcwr = z;
                end
                default: begin
                    e_state = 9; e_pcsrc = 2'b10; e_pcwr = 1;
                end
            endcase
        end
    endtask

    // Run one instruction (or its first `stop` cycles when stop > 0).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int stop);
        int c = cls_of(o, f);
        int n = (stop > 0) ? stop : len_of(c);
        for (int s = 0; s < n; s++) begin
            rst = 0; op = o; funct = f;
            zero = (c == CBeq && s == 2) ? z : 1'($urandom);
            exp_rst = 0;
            set_exp(c, s, zero);
            e_cnt = model_cnt;
            exp_valid = 1;
            @(posedge clk); #1;
            lit_en = 0; lit4_en = 0;
        end
        exp_valid = 0;
        if (stop == 0 && c != CIll) model_cnt = model_cnt + 1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1; op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
            exp_rst = 1; exp_valid = 1;
            @(posedge clk); #1;
            lit_en = 0; lit4_en = 0;
        end
        rst = 0; exp_rst = 0; exp_valid = 0;
        model_cnt = 0;
    endtask

    task automatic pin(input logic [31:0] v);
        lit_en = 1; lit_val = v;
    endtask

    task automatic pin4(input logic [31:0] v);
        lit4_en = 1; lit4_val = v;
    endtask

    initial begin
        #1;
        do_reset(2);
        pin(0); pin4(0);
        run_instr(6'b100011, 6'h00, 0, 0);          // lw
        pin(1);
        run_instr(6'b000000, 6'b100001, 0, 0);      // addu
        run_instr(6'b000000, 6'b100011, 0, 0);      // subu
        pin(3);
        run_instr(6'b000100, 6'h15, 1, 0);          // beq taken
        run_instr(6'b000100, 6'h2a, 0, 0);          // beq not taken
        pin(5);
        run_instr(6'b001101, 6'h3f, 0, 0);          // ori
        run_instr(6'b101011, 6'h21, 0, 0);          // sw
        pin(7);
        run_instr(6'b111111, 6'h00, 0, 0);          // illegal op
        run_instr(6'b000000, 6'b000000, 0, 0);      // illegal funct
        run_instr(6'b000000, 6'b100000, 0, 0);      // add (signed) unsupported
        pin(7);
        run_instr(6'b100011, 6'h00, 0, 3);          // lw up to MEM_ADR
        do_reset(1);                                // rst during MEM_RD
        pin(0); pin4(0);
        for (int i = 0; i < 16; i++) run_instr(6'b001101, 6'h00, 0, 0);
        pin(16); pin4(0);
        run_instr(6'b000010, 6'h00, 0, 0);          // j
        pin(17); pin4(1);
        run_instr(6'b000010, 6'h00, 0, 2);          // j, stopped before JUMP
        do_reset(2);                                // rst with FSM in JUMP then FETCH
        pin(0);
        run_instr(6'b100011, 6'h00, 0, 0);          // lw after reset
        pin(1);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
